uvma_axil_mem_slv: RTL and testbench
====================================

Name: uvma_axil_mem_slv

Overview:
- Synthesizable AXI-Lite slave memory model that drives the slave side of uvma_axil_if.
- Sits directly downstream of the bus, as the responder whose traffic the interface checker observes.
- Backs a word-addressed memory with independent write and read FSMs, a fixed response latency, and SLVERR on out-of-range accesses.
- Used as the default DUT stand-in for agent self-tests.

Parameters:
- ADDR_WIDTH, 32: width of awaddr/araddr.
- DATA_WIDTH, 32: data width. Legal values are 32 or 64. Strobe width is DATA_WIDTH/8.
- DEPTH, 256: number of memory words. Word index = addr >> log2(DATA_WIDTH/8).
- LATENCY, 0: extra idle cycles before bvalid/rvalid. Range 0..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  ignored.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- bresp  out  2  write response.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  ignored.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSMs go to IDLE; latency counters and memory are cleared to 0.
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0.
- First cycle after reset release: awready = wready = arready = 1.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_LAT, W_RESP.
  - awready = 1 only in W_IDLE or W_HAVE_W. wready = 1 only in W_IDLE or W_HAVE_AW.
  - AW and W are captured independently. Both handshaking in the same cycle counts as a simultaneous capture.
  - Commit cycle N = the cycle in which the second of AW/W handshakes. At the end of N, bytes with wstrb[i]=1 are written. wstrb = 0 is a legal no-op that still gets an OKAY response.
  - Word index >= DEPTH: no memory write, bresp = SLVERR (2'b10). Otherwise bresp = OKAY (2'b00).
  - LATENCY = 0: bvalid rises at N+1. Otherwise the FSM spends LATENCY cycles in W_LAT, then enters W_RESP.
  - bvalid and bresp are held stable until bready. The FSM returns to W_IDLE the cycle after the B handshake (readies high again at N+LATENCY+2 at the earliest).
- Read FSM states: R_IDLE, R_LAT, R_RESP.
  - arready = 1 only in R_IDLE.
  - On the AR handshake in cycle M, memory is sampled at the end of M.
  - rvalid rises at M+1+LATENCY. rdata and rresp are held until rready.
  - Out of range: rdata = 0, rresp = SLVERR.
  - Return to R_IDLE the cycle after the R handshake.
- Read/write collision: AR handshake in the same cycle as a write commit to the same word returns pre-write data. Any later AR returns post-write data.
- Write and read FSMs are fully concurrent; no ordering between channels.
- Address bits below the word offset are ignored (unaligned addresses are truncated).
- Reset asserted mid-transaction: in-flight transactions are dropped and no response is issued. A write whose commit cycle has already passed remains visible until reset clears memory.

Optional Feature:
- Macro: UVMA_AXIL_MEM_SLV_BP_EN.
- Defined:
  - An 8-bit LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - When lfsr[0] = 1, awready, wready and arready are forced to 0 that cycle (random backpressure). bvalid/rvalid are unaffected.
- Undefined: no LFSR; readies follow the FSMs only.

Decomposition:
- Package uvma_axil_mem_slv_pkg holds:
  - the resp typedef enum (OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11);
  - the write and read FSM state enums;
  - a function computing the word-offset bit count from DATA_WIDTH.
- One sub-module: uvma_axil_mem_slv_lat_cntr, a 4-bit load/decrement counter with a done flag, instantiated once per channel.

Test Plan:
- Simultaneous AW/W write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, LATENCY=2, bready=1 -> bvalid at N+3, bresp=OKAY; a later read of 0x10 returns rdata=0xDEADBEEF, rresp=OKAY.
- W sent 3 cycles before AW (wdata=0x11223344, wstrb=4'b0101, addr 0x20 previously 0) -> wready=0 while waiting for AW; a read of 0x20 returns 0x00220044.
- Write addr 0x400 with DEPTH=256 -> bresp=SLVERR and memory is unchanged; read of 0x400 -> rdata=0, rresp=SLVERR.
- rvalid held with rready=0 for 5 cycles -> rdata/rresp stable and arready=0 throughout; arready=1 the cycle after the R handshake.
- AR and write commit to 0x30 (old 0xA, new 0xB) in the same cycle -> rdata=0xA; the next read returns 0xB.
- reset_n pulsed low while in W_LAT -> all valids/readies 0 immediately; readies = 1 after release and no bvalid is ever emitted.

Source files
------------

// File: rtl/uvma_axil_mem_slv_pkg.sv
// rtl/uvma_axil_mem_slv_pkg.sv - shared types and helpers for the AXI-Lite slave memory model
package uvma_axil_mem_slv_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_LAT,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LAT,
    R_RESP
  } r_state_e;

  function automatic int word_off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/uvma_axil_mem_slv_lat_cntr.sv
// rtl/uvma_axil_mem_slv_lat_cntr.sv - 4-bit load/decrement latency counter with done flag
module uvma_axil_mem_slv_lat_cntr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/uvma_axil_mem_slv.sv
// rtl/uvma_axil_mem_slv.sv - AXI-Lite slave memory model; UVMA_AXIL_MEM_SLV_BP_EN enables LFSR backpressure
module uvma_axil_mem_slv
  import uvma_axil_mem_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = word_off_bits(DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic bp;

`ifdef UVMA_AXIL_MEM_SLV_BP_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign bp = lfsr[0];
`else
  assign bp = 1'b0;
`endif

  // Write channel: AW and W are accepted independently; the second one commits.
  w_state_e              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  resp_e                 bresp_q;
  logic                  aw_hs, w_hs, commit, w_lat_done;
  logic [ADDR_WIDTH-1:0] c_addr, c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic                  c_in_range;

  assign awready = reset_n && !bp && ((w_state == W_IDLE) || (w_state == W_HAVE_W));
  assign wready  = reset_n && !bp && ((w_state == W_IDLE) || (w_state == W_HAVE_AW));
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign bvalid  = (w_state == W_RESP);
  assign bresp   = bresp_q;

  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    c_addr      = awaddr;
    c_data      = wdata;
    c_strb      = wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) commit = 1'b1;
        else if (aw_hs)    w_state_nxt = W_HAVE_AW;
        else if (w_hs)     w_state_nxt = W_HAVE_W;
      end
      W_HAVE_AW: begin
        c_addr = aw_addr_q;
        if (w_hs) commit = 1'b1;
      end
      W_HAVE_W: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        if (aw_hs) commit = 1'b1;
      end
      W_LAT:   if (w_lat_done) w_state_nxt = W_RESP;
      W_RESP:  if (bready)     w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
    if (commit) w_state_nxt = (LATENCY == 0) ? W_RESP : W_LAT;
  end

  assign c_idx      = c_addr >> OFF;
  assign c_in_range = (c_idx < DEPTH_A);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) bresp_q <= c_in_range ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && c_in_range) begin
      for (int b = 0; b < STRB_W; b++)
        if (c_strb[b]) mem[c_idx[IDX_W-1:0]][b*8 +: 8] <= c_data[b*8 +: 8];
    end
  end

  uvma_axil_mem_slv_lat_cntr u_w_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (commit),
    .load_val (LAT_LOAD),
    .dec      (w_state == W_LAT),
    .done     (w_lat_done)
  );

  // Read channel: memory is sampled on the AR handshake, so a same-cycle write is not seen.
  r_state_e              r_state, r_state_nxt;
  logic                  ar_hs, r_in_range, r_lat_done;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_e                 rresp_q;

  assign arready    = reset_n && !bp && (r_state == R_IDLE);
  assign ar_hs      = arvalid && arready;
  assign r_idx      = araddr >> OFF;
  assign r_in_range = (r_idx < DEPTH_A);
  assign rvalid     = (r_state == R_RESP);
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)      r_state_nxt = (LATENCY == 0) ? R_RESP : R_LAT;
      R_LAT:   if (r_lat_done) r_state_nxt = R_RESP;
      R_RESP:  if (rready)     r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        rdata_q <= r_in_range ? mem[r_idx[IDX_W-1:0]] : '0;
        rresp_q <= r_in_range ? OKAY : SLVERR;
      end
    end
  end

  uvma_axil_mem_slv_lat_cntr u_r_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ar_hs),
    .load_val (LAT_LOAD),
    .dec      (r_state == R_LAT),
    .done     (r_lat_done)
  );

endmodule

// File: tb/tb_uvma_axil_mem_slv.sv
// tb/tb_uvma_axil_mem_slv.sv - scoreboard bench for uvma_axil_mem_slv (LATENCY=2, DEPTH=256)
module tb_uvma_axil_mem_slv;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr  = '0;
  logic [2:0]  awprot  = '0;
  logic        wvalid  = 1'b0;
  logic        wready;
  logic [31:0] wdata   = '0;
  logic [3:0]  wstrb   = '0;
  logic        bvalid;
  logic        bready  = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr  = '0;
  logic [2:0]  arprot  = '0;
  logic        rvalid;
  logic        rready  = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  uvma_axil_mem_slv #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .LATENCY    (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .arprot  (arprot),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t exp_b[$];
  exp_t exp_r[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [1:0] er);
    exp_t e;
    e.resp = er;
    e.data = '0;
    exp_b.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] ed, input logic [1:0] er);
    exp_t e;
    e.resp = er;
    e.data = ed;
    exp_r.push_back(e);
  endtask

  // Counts negedges after the handshake edge until the valid rises; LATENCY=2 gives 3.
  task automatic wait_lat(input string name, input logic is_b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_b ? bvalid : rvalid) && n < 20);
    chk(name, 32'(n), 32'd3);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    push_b(er);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    @(negedge clk);
    chk("wr_readies", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_lat("b_latency", 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    push_r(ed, er);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a;
    @(negedge clk);
    chk("rd_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_lat("r_latency", 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_b;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n && bvalid && bready) begin
          if (exp_b.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL b_unexpected: bresp 0x%0h with no expected response", bresp);
          end else begin
            e = exp_b.pop_front();
            chk("bresp", 32'(bresp), 32'(e.resp));
          end
        end
        if (reset_n && rvalid && rready) begin
          if (exp_r.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL r_unexpected: rdata 0x%0h with no expected response", rdata);
          end else begin
            e = exp_r.pop_front();
            chk("rdata", rdata, e.data);
            chk("rresp", 32'(rresp), 32'(e.resp));
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", 32'({awready, wready, arready}), 32'h7);

    // Simultaneous AW/W write, then read back
    wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(32'h10, 32'hDEADBEEF, 2'b00);

    // W leads AW by 3 cycles, partial strobes
    push_b(2'b00);
    @(posedge clk); #1;
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
    @(negedge clk);
    chk("wfirst_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wfirst_wready_wait", 32'(wready), 32'd0);
      chk("wfirst_awready_wait", 32'(awready), 32'd1);
    end
    awvalid = 1'b1; awaddr = 32'h20;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_lat("b_latency_wfirst", 1'b1);
    @(posedge clk); #1;
    rd(32'h20, 32'h00220044, 2'b00);

    // Out-of-range write and read
    wr(32'h400, 32'hCAFEF00D, 4'hF, 2'b10);
    rd(32'h0, 32'h0, 2'b00);
    rd(32'h400, 32'h0, 2'b10);

    // rvalid stall with rready low
    rready = 1'b0;
    push_r(32'hDEADBEEF, 2'b00);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h12;
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_lat("r_latency_stall", 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid",  32'(rvalid),  32'd1);
      chk("stall_rdata",   rdata,        32'hDEADBEEF);
      chk("stall_rresp",   32'(rresp),   32'd0);
      chk("stall_arready", 32'(arready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_r_hs_arready", 32'(arready), 32'd1);
    chk("post_r_hs_rvalid",  32'(rvalid),  32'd0);

    // Read/write collision on 0x30
    wr(32'h30, 32'hA, 4'hF, 2'b00);
    push_b(2'b00);
    push_r(32'hA, 2'b00);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b1; wdata = 32'hB; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h30;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_lat("b_latency_coll", 1'b1);
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    @(posedge clk); #1;
    rd(32'h30, 32'hB, 2'b00);

    // Reset while the write sits in W_LAT
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = 32'h40; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_readies", 32'({awready, wready, arready}), 32'h7);
    seen_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bvalid) seen_b = 1'b1;
    end
    chk("midrst_no_bvalid", 32'(seen_b), 32'd0);
    rd(32'h40, 32'h0, 2'b00);
    rd(32'h10, 32'h0, 2'b00);

    repeat (5) @(negedge clk);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
